// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC / IF-ID / ID-EX enables and flushes, hazard
// arbitration, saturating perf counters and a sticky imem timeout flag.
module fetch_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_stall,
  input  logic        jump_en,
  input  logic        load_use_hazard,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        fetch_valid,
  output logic [1:0]  state,
  output logic [15:0] flush_count,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);

  // state    | meaning
  // INIT     | post-reset bubbles, inputs ignored
  // RUN      | normal fetch
  // STALL    | last cycle held by ex_stall or load-use
  // MEM_WAIT | last cycle waited on instruction memory
  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_STALL    = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  always_comb begin
    pc_en          = 1'b0;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b1;
    idex_flush     = 1'b1;
    fetch_valid    = 1'b0;
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    flush_count_d  = flush_count_q;
    stall_cycles_d = stall_cycles_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;

    if (rst) begin
      state_d = S_INIT;
    end else if (state_q == S_INIT) begin
      if (init_cnt_q >= INIT_LAST) state_d = S_RUN;
      else                         init_cnt_d = init_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = '0;
      if (ex_stall) begin
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        state_d        = S_STALL;
        stall_cycles_d = (stall_cycles_q == 16'hFFFF) ? stall_cycles_q : stall_cycles_q + 16'd1;
      end else if (jump_en) begin
        pc_en         = 1'b1;
        state_d       = S_RUN;
        flush_count_d = (flush_count_q == 16'hFFFF) ? flush_count_q : flush_count_q + 16'd1;
      end else if (load_use_hazard) begin
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        state_d        = S_STALL;
        stall_cycles_d = (stall_cycles_q == 16'hFFFF) ? stall_cycles_q : stall_cycles_q + 16'd1;
      end else if (!imem_ready) begin
        idex_flush = 1'b0;
        state_d    = S_MEM_WAIT;
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        fetch_valid = 1'b1;
        state_d     = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_INIT;
      init_cnt_q     <= '0;
      flush_count_q  <= '0;
      stall_cycles_q <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      flush_count_q  <= flush_count_d;
      stall_cycles_q <= stall_cycles_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign state        = state_q;
  assign flush_count  = flush_count_q;
  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_stall = 1'b0, jump_en = 1'b0, load_use_hazard = 1'b0, imem_ready = 1'b1;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, fetch_valid, mem_timeout;
  logic [1:0]  state;
  logic [15:0] flush_count, stall_cycles;

  fetch_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .jump_en(jump_en),
    .load_use_hazard(load_use_hazard), .imem_ready(imem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fetch_valid(fetch_valid), .state(state),
    .flush_count(flush_count), .stall_cycles(stall_cycles),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_MW = 2'd3;
  // control vector {pc_en, ifid_en, ifid_flush, idex_flush, fetch_valid}
  localparam logic [4:0] C_RST = 5'b01110, C_RUN = 5'b11001, C_EXS = 5'b00000,
                         C_JMP = 5'b11110, C_LU  = 5'b00010, C_MW  = 5'b01100;
  localparam logic [4:0] ALL = 5'b11111, NO_IFF = 5'b11011;

  typedef struct {
    string       nm;
    logic [1:0]  st;
    bit          st_care;
    logic [4:0]  ctl;
    logic [4:0]  care;
    logic [15:0] fc;
    logic [15:0] sc;
    logic        mt;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 0, exp_sc = 0;
  logic        exp_mt = 0;

  task automatic cmp(string nm, string fld, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: outputs are Mealy, so sample mid-cycle after inputs settle.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idex_flush, fetch_valid};
        if (e.st_care) cmp(e.nm, "state", 16'(state), 16'(e.st));
        if (e.care[4]) cmp(e.nm, "pc_en",       16'(act[4]), 16'(e.ctl[4]));
        if (e.care[3]) cmp(e.nm, "ifid_en",     16'(act[3]), 16'(e.ctl[3]));
        if (e.care[2]) cmp(e.nm, "ifid_flush",  16'(act[2]), 16'(e.ctl[2]));
        if (e.care[1]) cmp(e.nm, "idex_flush",  16'(act[1]), 16'(e.ctl[1]));
        if (e.care[0]) cmp(e.nm, "fetch_valid", 16'(act[0]), 16'(e.ctl[0]));
        cmp(e.nm, "flush_count",  flush_count,  e.fc);
        cmp(e.nm, "stall_cycles", stall_cycles, e.sc);
        cmp(e.nm, "mem_timeout",  16'(mem_timeout), 16'(e.mt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(string nm, bit r, bit es, bit je, bit lu, bit ir,
                      logic [1:0] st, bit stc, logic [4:0] ctl, logic [4:0] care);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_stall = es; jump_en = je; load_use_hazard = lu; imem_ready = ir;
    e.nm = nm; e.st = st; e.st_care = stc; e.ctl = ctl; e.care = care;
    e.fc = exp_fc; e.sc = exp_sc; e.mt = exp_mt;
    q.push_back(e);
  endtask

  // One reset cycle then the two INIT bubbles; returns with RUN next.
  task automatic do_reset();
    step("rst", 1, 0, 0, 0, 1, S_INIT, 0, C_RST, ALL);
    exp_fc = 0; exp_sc = 0; exp_mt = 0;
    step("init0", 0, 1, 1, 1, 0, S_INIT, 1, C_RST, ALL);
    step("init1", 0, 0, 0, 0, 1, S_INIT, 1, C_RST, ALL);
  endtask

  initial begin
    // startup: state 0,0,1 and first fetch in 3rd cycle after release
    do_reset();
    step("first_fetch", 0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);
    step("run2",        0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);

    // load-use for one cycle
    do_reset();
    step("lu",        0, 0, 0, 1, 1, S_RUN, 1, C_LU, NO_IFF);
    exp_sc = 1;
    step("lu_after",  0, 0, 0, 0, 1, S_STALL, 1, C_RUN, ALL);
    step("lu_run",    0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);
    step("jump_lu",   0, 0, 1, 1, 1, S_RUN, 1, C_JMP, ALL);
    exp_fc = 1;
    step("exs_lu",    0, 1, 0, 1, 1, S_RUN, 1, C_EXS, NO_IFF);
    exp_sc = 2;
    step("exs_lu_rt", 0, 0, 0, 0, 1, S_STALL, 1, C_RUN, ALL);

    // ex_stall + jump for 3 cycles, then jump alone
    do_reset();
    step("exs_j1", 0, 1, 1, 0, 1, S_RUN, 1, C_EXS, NO_IFF);
    exp_sc = 1;
    step("exs_j2", 0, 1, 1, 0, 1, S_STALL, 1, C_EXS, NO_IFF);
    exp_sc = 2;
    step("exs_j3", 0, 1, 1, 0, 1, S_STALL, 1, C_EXS, NO_IFF);
    exp_sc = 3;
    step("jump",   0, 0, 1, 0, 1, S_STALL, 1, C_JMP, ALL);
    exp_fc = 1;
    step("post_j", 0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);

    // imem wait states with MEM_TIMEOUT=4
    do_reset();
    step("mw_a1", 0, 0, 0, 0, 0, S_RUN, 1, C_MW, ALL);
    step("mw_a2", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_a3", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_b",  0, 0, 0, 0, 1, S_MW,  1, C_RUN, ALL);
    step("mw_c1", 0, 0, 0, 0, 0, S_RUN, 1, C_MW, ALL);
    step("mw_c2", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_jmp", 0, 0, 1, 0, 0, S_MW, 1, C_JMP, ALL);
    exp_fc = 1;
    step("mw_d1", 0, 0, 0, 0, 0, S_RUN, 1, C_MW, ALL);
    step("mw_d2", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_d3", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_e",  0, 0, 0, 0, 1, S_MW,  1, C_RUN, ALL);
    step("mw_f1", 0, 0, 0, 0, 0, S_RUN, 1, C_MW, ALL);
    step("mw_f2", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_f3", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    step("mw_f4", 0, 0, 0, 0, 0, S_MW,  1, C_MW, ALL);
    exp_mt = 1;
    step("mt_g",  0, 0, 0, 0, 1, S_MW,  1, C_RUN, ALL);
    step("mt_h",  0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);
    do_reset();
    step("mt_clr", 0, 0, 0, 0, 1, S_RUN, 1, C_RUN, ALL);

    // flush_count saturation, then reset mid-run
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      step("jump_sat", 0, 0, 1, 0, 1, S_RUN, 1, C_JMP, ALL);
      if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    end
    step("sat_rst",  1, 0, 1, 0, 1, S_RUN,  1, C_RST, ALL);
    exp_fc = 0; exp_sc = 0; exp_mt = 0;
    step("rst_i0",   0, 0, 1, 0, 1, S_INIT, 1, C_RST, ALL);
    step("rst_i1",   0, 0, 1, 0, 1, S_INIT, 1, C_RST, ALL);
    step("rst_run",  0, 0, 0, 0, 1, S_RUN,  1, C_RUN, ALL);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. It drives the PC enable and the IF/ID and ID/EX pipeline-register enables and flushes. It arbitrates between execute stalls, jump/mispredict redirects, load-use hazards and instruction-memory wait states. It also keeps saturating performance counters and a sticky instruction-memory timeout flag, and sits between the hazard unit, the execute stage and the fetch stage.

## Interface
Parameters:
- INIT_CYCLES, 2, number of bubble cycles after reset release before fetching starts (minimum 1).
- MEM_TIMEOUT, 16, number of consecutive not-ready cycles that sets mem_timeout (range 1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_stall  in  1  execute stage holding (multi-cycle op); its jump result is not final.
- jump_en  in  1  execute stage redirect (taken jump or BTB mispredict); the PC loads pc_jump_addr when pc_en=1.
- load_use_hazard  in  1  ID-stage load-use stall request.
- imem_ready  in  1  instruction memory returns a valid instruction this cycle (tie high for a combinational memory).
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load a bubble into IF/ID (valid only when ifid_en=1).
- idex_flush  out  1  load a bubble into ID/EX.
- fetch_valid  out  1  IF/ID captures a real instruction at this edge.
- state  out  2  FSM state: INIT=0, RUN=1, STALL=2, MEM_WAIT=3.
- flush_count  out  16  number of accepted redirects, saturating at 0xFFFF.
- stall_cycles  out  16  number of hold cycles from ex_stall or load_use, saturating.
- mem_timeout  out  1  sticky error flag; cleared only by rst.

## Operation
- Control outputs are Mealy: a combinational function of state and the current inputs. The state, counters and flag are registered.
- While rst=1:
  - pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=1, fetch_valid=0.
  - Next state INIT, init counter 0, flush_count=0, stall_cycles=0, wait counter 0, mem_timeout=0.
- INIT:
  - Outputs pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=1, fetch_valid=0.
  - All hazard and jump inputs are ignored and no counters change.
  - Stays in INIT for INIT_CYCLES cycles, then goes to RUN.
- RUN, STALL and MEM_WAIT evaluate the following fixed priority each cycle. The first matching case applies.
  1. ex_stall:
     - pc_en=0, ifid_en=0, idex_flush=0, fetch_valid=0.
     - Next state STALL; stall_cycles increments.
  2. jump_en:
     - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, fetch_valid=0.
     - Next state RUN; flush_count increments.
     - imem_ready is ignored in this cycle.
  3. load_use_hazard:
     - pc_en=0, ifid_en=0, idex_flush=1, fetch_valid=0.
     - Next state STALL; stall_cycles increments.
  4. !imem_ready:
     - pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=0, fetch_valid=0.
     - Next state MEM_WAIT.
  5. Otherwise:
     - pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, fetch_valid=1.
     - Next state RUN.
- The wait counter (8 bits) rules:
  - It increments on every case-4 cycle and clears to 0 on any other case.
  - When case 4 occurs with the wait counter at MEM_TIMEOUT-1, mem_timeout is set at that edge.
  - The wait counter saturates at 255.
- Counters saturate: once a counter reaches 0xFFFF it holds that value.

## Timing
- Outputs respond to inputs in the same cycle, with zero-cycle latency from a hazard to pc_en.
- The first valid fetch (fetch_valid=1) comes in the (INIT_CYCLES+1)-th cycle after rst falls, provided no hazard is present.
- A redirect takes one cycle. The target instruction can be valid in the next cycle.
- Simultaneous events:
  - ex_stall together with jump_en: the stall wins, and the jump is re-presented by EX later.
  - jump_en together with load_use_hazard: the redirect wins. The stalled instruction is squashed by ifid_flush.
- Reset mid-operation: rst overrides every state on the next edge. Counters and mem_timeout clear in the same edge.

## Test plan
- Reset release with INIT_CYCLES=2 and no hazards: state reads 0,0,1. fetch_valid first goes high in the 3rd cycle after rst falls, and pc_en=1 from that cycle on.
- load_use_hazard high for 1 cycle in RUN: that cycle gives pc_en=0, ifid_en=0, idex_flush=1, state→STALL. Afterwards it returns to RUN and stall_cycles=1.
- ex_stall and jump_en both high for 3 cycles, then jump_en alone for 1 cycle:
  - The 3 stall cycles give pc_en=0 and leave flush_count at 0, with stall_cycles=3.
  - The following cycle gives pc_en=1, ifid_flush=1, idex_flush=1, and flush_count=1.
- imem_ready low with MEM_TIMEOUT=4:
  - A 3-cycle low gives state MEM_WAIT, ifid_flush=1, and mem_timeout stays 0.
  - A 4-cycle low sets mem_timeout=1. It stays 1 after imem_ready returns and clears only on rst.
- Hold jump_en for 70000 cycles: flush_count saturates at 0xFFFF. Then assert rst for 1 cycle: flush_count=0 and state=INIT.
